decoder_scan_reg: RTL and testbench

// - Registered, parametrised binary-to-one-hot decoder with a built-in scan (running-light) mode.
// - Decode mode: loads a SEL_W-bit index and holds its one-hot output until the next load.
// - Scan mode: steps the active bit automatically every DIV clocks.
// - Drives LED banks / digit enables in lab designs; replaces the fixed 3-to-8 combinational decoder.

---
 rtl/decoder_scan_reg.sv | 112 +++++++++++
 tb/tb_decoder_scan_reg.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/decoder_scan_reg.sv
// Registered binary-to-one-hot decoder with a scan (running-light) mode.
// Optional macro DEC_PINGPONG_EN: scan bounces at the ends instead of wrapping.
module decoder_scan_reg #(
  parameter int SEL_W     = 3,
  parameter int DIV       = 4,
  parameter int RESET_IDX = 0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic                load,
  input  logic                dir,
  output logic [2**SEL_W-1:0] out,
  output logic [SEL_W-1:0]    idx,
  output logic                step
);

  localparam int OUT_W = 2**SEL_W;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [OUT_W-1:0] r_out;
  logic [SEL_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_step;
  logic             r_prev_mode;

  logic [SEL_W-1:0] w_idx_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_step_nxt;

  function automatic logic [SEL_W-1:0] idx_move(input logic [SEL_W-1:0] cur,
                                                input logic down);
    return down ? cur - SEL_W'(1) : cur + SEL_W'(1);
  endfunction

`ifdef DEC_PINGPONG_EN
  logic r_bdir;
  logic w_bdir_nxt;
  logic w_at_end;

  // Reaching the end in the current direction reverses before moving.
  assign w_at_end = r_bdir ? (r_idx == '0) : (r_idx == '1);
`endif

  always_comb begin
    w_idx_nxt  = r_idx;
    w_cnt_nxt  = r_cnt;
    w_step_nxt = 1'b0;
`ifdef DEC_PINGPONG_EN
    w_bdir_nxt = r_bdir;
`endif
    if (load) begin
      w_idx_nxt = sel;
      w_cnt_nxt = '0;
`ifdef DEC_PINGPONG_EN
      w_bdir_nxt = dir;
`endif
    end else if (mode != r_prev_mode) begin
      w_cnt_nxt = '0;
`ifdef DEC_PINGPONG_EN
      if (mode) w_bdir_nxt = dir;
`endif
    end else if (mode) begin
      if (r_cnt == CNT_MAX) begin
        w_cnt_nxt  = '0;
        w_step_nxt = 1'b1;
`ifdef DEC_PINGPONG_EN
        if (w_at_end) begin
          w_bdir_nxt = ~r_bdir;
          w_idx_nxt  = idx_move(r_idx, ~r_bdir);
        end else begin
          w_idx_nxt  = idx_move(r_idx, r_bdir);
        end
`else
        w_idx_nxt = idx_move(r_idx, dir);
`endif
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_idx       <= SEL_W'(RESET_IDX);
      r_out       <= OUT_W'(1) << RESET_IDX;
      r_cnt       <= '0;
      r_step      <= 1'b0;
      r_prev_mode <= 1'b0;
    end else begin
      r_idx       <= w_idx_nxt;
      r_out       <= OUT_W'(1) << w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_step      <= w_step_nxt;
      r_prev_mode <= mode;
    end
  end

`ifdef DEC_PINGPONG_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_bdir <= dir;
    else         r_bdir <= w_bdir_nxt;
  end
`endif

  assign out  = r_out;
  assign idx  = r_idx;
  assign step = r_step;

endmodule

// File: tb/tb_decoder_scan_reg.sv
// Scoreboard bench for decoder_scan_reg: two instances (DIV=4 and DIV=1) share stimulus.
module tb_decoder_scan_reg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst, mode, load, dir;
  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] out_a, out_b;
  logic [SEL_W-1:0] idx_a, idx_b;
  logic             step_a, step_b;

  always #5 clk = ~clk;

  decoder_scan_reg #(.SEL_W(SEL_W), .DIV(4), .RESET_IDX(0)) u_dut (
    .sys_clk(clk), .sys_rst(rst), .mode(mode), .sel(sel), .load(load), .dir(dir),
    .out(out_a), .idx(idx_a), .step(step_a));

  decoder_scan_reg #(.SEL_W(SEL_W), .DIV(1), .RESET_IDX(0)) u_dut1 (
    .sys_clk(clk), .sys_rst(rst), .mode(mode), .sel(sel), .load(load), .dir(dir),
    .out(out_b), .idx(idx_b), .step(step_b));

  typedef struct {
    int idx;
    int step;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: one entry per instance.
  int divs[2]   = '{4, 1};
  int m_idx[2];
  int m_cnt[2];
  int m_prev[2];
  int m_step[2];
  int m_bdir[2];

  task automatic model(input int k, input int r, input int ld, input int md,
                       input int s, input int d);
    int mv;
    if (r != 0) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_prev[k] = 0; m_step[k] = 0; m_bdir[k] = d;
      return;
    end
    m_step[k] = 0;
    if (ld != 0) begin
      m_idx[k] = s; m_cnt[k] = 0; m_bdir[k] = d;
    end else if (md != m_prev[k]) begin
      m_cnt[k] = 0;
      if (md != 0) m_bdir[k] = d;
    end else if (md != 0) begin
      if (m_cnt[k] == divs[k] - 1) begin
        m_cnt[k]  = 0;
        m_step[k] = 1;
`ifdef DEC_PINGPONG_EN
        if (m_bdir[k] == 0 && m_idx[k] == OUT_W - 1) m_bdir[k] = 1;
        else if (m_bdir[k] == 1 && m_idx[k] == 0) m_bdir[k] = 0;
        mv = (m_bdir[k] != 0) ? -1 : 1;
`else
        mv = (d != 0) ? -1 : 1;
`endif
        m_idx[k] = (m_idx[k] + mv + OUT_W) % OUT_W;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
    m_prev[k] = md;
  endtask

  task automatic cyc(input int r, input int ld, input int md, input int s, input int d);
    exp_t e;
    @(negedge clk);
    rst = r[0]; load = ld[0]; mode = md[0]; sel = s[SEL_W-1:0]; dir = d[0];
    for (int k = 0; k < 2; k++) model(k, r, ld, md, s, d);
    e.idx = m_idx[0]; e.step = m_step[0]; q_a.push_back(e);
    e.idx = m_idx[1]; e.step = m_step[1]; q_b.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle, so pop one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("div4_idx",  int'(idx_a), e.idx);
        chk("div4_out",  int'(out_a), 1 << e.idx);
        chk("div4_step", int'(step_a), e.step);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("div1_idx",  int'(idx_b), e.idx);
        chk("div1_out",  int'(out_b), 1 << e.idx);
        chk("div1_step", int'(step_b), e.step);
      end
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; mode = 1'b0; sel = '0; dir = 1'b0;
    // Reset, then hold in decode mode
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 7, 1);
    // Decode load, then sel changes without load
    cyc(0, 1, 0, 5, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 2, 0);
    // Scan up from 6 with wrap
    cyc(0, 1, 0, 6, 0);
    for (int i = 0; i < 14; i++) cyc(0, 0, 1, 0, 0);
    // Scan down from 1 (DIV=1 instance runs 1,0,7,...)
    cyc(0, 1, 1, 1, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 1);
    // Load mid-period during scan up, period restarts
    cyc(0, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 3, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0, 0);
    // Direction change mid-scan and mid-run reset
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 1);
    cyc(1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r, ld, md;
      r  = ($urandom_range(0, 99) < 2) ? 1 : 0;
      ld = ($urandom_range(0, 99) < 8) ? 1 : 0;
      md = ($urandom_range(0, 99) < 6) ? int'(~mode) & 1 : int'(mode);
      cyc(r, ld, md, int'($urandom_range(0, OUT_W - 1)), int'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, required 0", q_a.size(), q_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
